mem_arbiter: RTL

- Shares the single byte-wide MemoryController among three requesters: PPU (port 1), CPU (port 0) and cart loader/DMA (port 2).
- Sequences the controller's one-cycle strobe / busy protocol.
- Returns read data to the winning requester together with a one-cycle ack.
- Sits between the NES core and the MemoryController; only this block drives the controller's strobes.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and MemoryController signals of mem_arbiter.
// master = arbiter side, slave = requesters plus controller side.
interface mem_arbiter_if #(
   parameter int AW = 22
);
   logic          req0, req1, req2;
   logic          we0, we1, we2;
   logic [AW-1:0] addr0, addr1, addr2;
   logic [7:0]    wdata0, wdata1, wdata2;
   logic          ack0, ack1, ack2;
   logic [7:0]    rdata0, rdata1, rdata2;
   logic          mc_read_a;
   logic          mc_read_b;
   logic          mc_write;
   logic [AW-1:0] mc_addr;
   logic [7:0]    mc_din;
   logic [7:0]    mc_dout_a;
   logic [7:0]    mc_dout_b;
   logic          mc_busy;

   modport master (
      input  req0, req1, req2,
      input  we0, we1, we2,
      input  addr0, addr1, addr2,
      input  wdata0, wdata1, wdata2,
      output ack0, ack1, ack2,
      output rdata0, rdata1, rdata2,
      output mc_read_a, mc_read_b, mc_write,
      output mc_addr, mc_din,
      input  mc_dout_a, mc_dout_b, mc_busy
   );

   modport slave (
      output req0, req1, req2,
      output we0, we1, we2,
      output addr0, addr1, addr2,
      output wdata0, wdata1, wdata2,
      input  ack0, ack1, ack2,
      input  rdata0, rdata1, rdata2,
      input  mc_read_a, mc_read_b, mc_write,
      input  mc_addr, mc_din,
      output mc_dout_a, mc_dout_b, mc_busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide MemoryController among CPU (0),
// PPU (1) and cart loader/DMA (2); fixed priority 1 > 0 > 2.
// Ports: clk, reset_n (async, active low), bus (mem_arbiter_if.master):
//   reqN/weN/addrN/wdataN in, ackN/rdataN out per requester,
//   mc_read_a/mc_read_b/mc_write/mc_addr/mc_din out, mc_dout_a/b, mc_busy in.
// Option: define MEM_ARB_STARVE_GUARD_EN to let the CPU win after
//   STARVE_LIMIT consecutive losses to the PPU.
module mem_arbiter #(
   parameter int AW           = 22,
   parameter int STARVE_LIMIT = 4
) (
   input logic           clk,
   input logic           reset_n,
   mem_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // The starvation counter is 3 bits wide.
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
      $error("mem_arbiter: STARVE_LIMIT must be 1..7");
   end

   state_t        state_q, state_d;
   logic [2:0]    gnt_q, gnt_d;
   logic          we_q, we_d;
   logic          rd_a_q, rd_a_d;
   logic          rd_b_q, rd_b_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    din_q, din_d;
   logic [2:0]    ack_q, ack_d;
   logic [7:0]    rdata0_q, rdata0_d;
   logic [7:0]    rdata1_q, rdata1_d;
   logic [7:0]    rdata2_q, rdata2_d;

   logic [2:0]    req_v;
   logic [2:0]    win;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [7:0]    sel_din;
   logic          force0;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
   logic [2:0] starve_q, starve_d;

   assign force0 = (starve_q >= LIMIT);
`else
   assign force0 = 1'b0;
`endif

   // A port whose ack is high this cycle is still holding req from the
   // access just finished; it must not be granted again.
   assign req_v = {bus.req2, bus.req1, bus.req0} & ~ack_q;

   always_comb begin
      win = 3'b000;
      priority case (1'b1)
         force0 && req_v[0]: win = 3'b001;
         req_v[1]:           win = 3'b010;
         req_v[0]:           win = 3'b001;
         req_v[2]:           win = 3'b100;
         default:            win = 3'b000;
      endcase
   end

   always_comb begin
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_din  = 8'h00;
      unique case (1'b1)
         win[0]: begin
            sel_we   = bus.we0;
            sel_addr = bus.addr0;
            sel_din  = bus.wdata0;
         end
         win[1]: begin
            sel_we   = bus.we1;
            sel_addr = bus.addr1;
            sel_din  = bus.wdata1;
         end
         win[2]: begin
            sel_we   = bus.we2;
            sel_addr = bus.addr2;
            sel_din  = bus.wdata2;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      din_d    = din_q;
      rd_a_d   = 1'b0;
      rd_b_d   = 1'b0;
      wr_d     = 1'b0;
      ack_d    = 3'b000;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_d = starve_q;
`endif
      unique case (state_q)
         IDLE: begin
            // Busy low also covers an access left in flight by a reset.
            if (!bus.mc_busy && (|req_v)) begin
               gnt_d   = win;
               we_d    = sel_we;
               addr_d  = sel_addr;
               din_d   = sel_din;
               wr_d    = sel_we;
               rd_b_d  = !sel_we && win[1];
               rd_a_d  = !sel_we && !win[1];
               state_d = ISSUE;
`ifdef MEM_ARB_STARVE_GUARD_EN
               if (win[0]) begin
                  starve_d = 3'd0;
               end else if (win[1] && req_v[0] &&
                            starve_q != 3'd7) begin
                  starve_d = starve_q + 3'd1;
               end
`endif
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (!bus.mc_busy) begin
               ack_d = gnt_q;
               if (!we_q) begin
                  unique case (1'b1)
                     gnt_q[0]: rdata0_d = bus.mc_dout_a;
                     gnt_q[1]: rdata1_d = bus.mc_dout_b;
                     gnt_q[2]: rdata2_d = bus.mc_dout_a;
                     default: ;
                  endcase
               end
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         gnt_q    <= 3'b000;
         we_q     <= 1'b0;
         rd_a_q   <= 1'b0;
         rd_b_q   <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= 8'h00;
         ack_q    <= 3'b000;
         rdata0_q <= 8'h00;
         rdata1_q <= 8'h00;
         rdata2_q <= 8'h00;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         we_q     <= we_d;
         rd_a_q   <= rd_a_d;
         rd_b_q   <= rd_b_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         ack_q    <= ack_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
      end
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_q <= 3'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`endif

   assign bus.ack0      = ack_q[0];
   assign bus.ack1      = ack_q[1];
   assign bus.ack2      = ack_q[2];
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.rdata2    = rdata2_q;
   assign bus.mc_read_a = rd_a_q;
   assign bus.mc_read_b = rd_b_q;
   assign bus.mc_write  = wr_q;
   assign bus.mc_addr   = addr_q;
   assign bus.mc_din    = din_q;

endmodule
